// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: schedules bytes from two valid/ready requesters onto a
// UART byte serializer that has no busy output. The frame length is timed
// locally so the serializer is never started while it is still shifting.
// Optional build macro: UART_TX_ARB_PRIO_EN selects fixed priority (channel 0
// always wins a contention) instead of the default round-robin.
module uart_tx_arbiter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);

  localparam int TICKS        = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_CYCLES = 10 * (TICKS + 1);
  localparam int HOLD_CYCLES  = FRAME_CYCLES + GAP_CYCLES;
  localparam int CNT_W        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             grant_q, grant_d;

  logic             winner;
  logic             accept;

  // Pick the channel that would be served if a transfer happens this cycle.
  always_comb begin
`ifdef UART_TX_ARB_PRIO_EN
    winner = ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      winner = ~grant_q;
    end else begin
      winner = ~req0_valid;
    end
`endif
  end

  // A byte is taken only in IDLE, out of reset, when someone is offering one.
  assign accept = (state_q == S_IDLE) && rst_n && (req0_valid || req1_valid);

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
    end
  end

  // Next state: leave IDLE on a transfer, return once the hold count expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch the winner's byte and arm the frame timer.
  always_comb begin
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    if (accept) begin
      cnt_d      = CNT_LOAD;
      tx_start_d = 1'b1;
      tx_data_d  = winner ? req1_data : req0_data;
      grant_d    = winner;
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Outputs: ready goes only to the winning channel, and only in the transfer cycle.
  always_comb begin
    req0_ready = accept && !winner;
    req1_ready = accept && winner;
    tx_start   = tx_start_q;
    tx_data    = tx_data_q;
    busy       = (state_q == S_WAIT);
    grant_id   = grant_q;
  end

endmodule
